// File: rtl/fifo_arbiter.sv
// Round-robin arbiter draining four source FIFOs into one destination FIFO.
// Latency: read_enable in cycle N, word pushed (write_enable/data_out) in N+2.
// Backpressure: dest_almost_full or init blocks new pops; up to 2 in-flight words still complete.
module fifo_arbiter #(
  parameter int TAMANO_DATOS = 10,
  parameter int N_FUENTES    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [7:0]              umbral_alto_in,
  input  logic [7:0]              umbral_bajo_in,
  input  logic [N_FUENTES-1:0]    empty,
  input  logic [TAMANO_DATOS-1:0] data_in0,
  input  logic [TAMANO_DATOS-1:0] data_in1,
  input  logic [TAMANO_DATOS-1:0] data_in2,
  input  logic [TAMANO_DATOS-1:0] data_in3,
  input  logic                    dest_almost_full,
  input  logic                    dest_full,
  output logic [N_FUENTES-1:0]    read_enable,
  output logic                    write_enable,
  output logic [TAMANO_DATOS-1:0] data_out,
  output logic [7:0]              umbral_alto,
  output logic [7:0]              umbral_bajo,
  output logic [1:0]              state,
  output logic                    error
);

  // Source index is 2 bits wide because the block serves exactly four sources.
  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [1:0]              last_grant;
  logic [1:0]              grant_idx;
  logic [1:0]              scan_idx;
  logic                    grant_vld;
  logic                    any_ready;
  logic                    pop_ok;
  logic                    s1_vld;
  logic [1:0]              s1_sel;
  logic                    s2_vld;
  logic [TAMANO_DATOS-1:0] data_mux;
  logic [7:0]              umbral_alto_q;
  logic [7:0]              umbral_bajo_q;
  logic [TAMANO_DATOS-1:0] data_out_q;
  logic                    error_q;

  assign any_ready = ~&empty;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; init overrides every other transition out of IDLE/ACTIVE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (init)                                state_d = ST_INIT;
        else if (any_ready && !dest_almost_full) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)                                state_d = ST_INIT;
        else if (!any_ready || dest_almost_full) state_d = ST_IDLE;
      end
      default:   state_d = ST_RESET;
    endcase
  end

  // Round-robin search: first non-empty source after the last one served.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_grant;
    scan_idx  = last_grant;
    for (int k = 1; k <= N_FUENTES; k++) begin
      scan_idx = last_grant + 2'(k);
      if (!grant_vld && !empty[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Pop strobe: IDLE covers the IDLE->ACTIVE cycle, since IDLE with a ready
  // source and no backpressure always moves to ACTIVE on the next edge.
  always_comb begin
    pop_ok      = ((state_q == ST_ACTIVE) || (state_q == ST_IDLE)) && !init && !dest_almost_full;
    read_enable = '0;
    if (pop_ok && grant_vld) begin
      read_enable = N_FUENTES'(1) << grant_idx;
    end
  end

  // Remember the most recently served source for the round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 2'd3;
    end else if (|read_enable) begin
      last_grant <= grant_idx;
    end
  end

  // Pick the word of the source popped in the previous cycle.
  always_comb begin
    data_mux = data_in0;
    case (s1_sel)
      2'd0:    data_mux = data_in0;
      2'd1:    data_mux = data_in1;
      2'd2:    data_mux = data_in2;
      default: data_mux = data_in3;
    endcase
  end

  // Two-stage pop pipeline: stage 1 waits for the source's registered output,
  // stage 2 presents the captured word to the destination.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld     <= 1'b0;
      s1_sel     <= 2'd0;
      s2_vld     <= 1'b0;
      data_out_q <= '0;
    end else begin
      s1_vld <= |read_enable;
      s1_sel <= grant_idx;
      s2_vld <= s1_vld;
      if (s1_vld) begin
        data_out_q <= data_mux;
      end
    end
  end

  // Thresholds follow the inputs while configuring and hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      umbral_alto_q <= 8'd0;
      umbral_bajo_q <= 8'd0;
    end else if (state_q == ST_INIT) begin
      umbral_alto_q <= umbral_alto_in;
      umbral_bajo_q <= umbral_bajo_in;
    end
  end

  // Sticky overflow: a push presented while the destination reports full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_q <= 1'b0;
    end else if (s2_vld && dest_full) begin
      error_q <= 1'b1;
    end
  end

  assign write_enable = s2_vld;
  assign data_out     = data_out_q;
  assign umbral_alto  = umbral_alto_q;
  assign umbral_bajo  = umbral_bajo_q;
  assign state        = state_q;
  assign error        = error_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter: behavioural source FIFOs plus a pop-to-push scoreboard.
// Latency: expected words are due two cycles after their pop strobe.
// Backpressure: dest_almost_full / dest_full driven directly by the stimulus.
module tb_fifo_arbiter;
  localparam int TD = 10;

  typedef struct {
    logic [TD-1:0] w;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          init = 1'b0;
  logic [7:0]    ua_in = 8'd0;
  logic [7:0]    ub_in = 8'd0;
  logic [3:0]    empty = 4'hF;
  logic [TD-1:0] din [4] = '{default: '0};
  logic          af = 1'b0;
  logic          full = 1'b0;
  logic [3:0]    read_enable;
  logic          write_enable;
  logic [TD-1:0] data_out;
  logic [7:0]    umbral_alto;
  logic [7:0]    umbral_bajo;
  logic [1:0]    state;
  logic          error;

  logic [TD-1:0] srcq [4][$];
  exp_t          expq [$];
  exp_t          e;
  int            gq [$];
  int            pcq [$];
  logic [3:0]    empty_nx;
  int checks = 0, failures = 0, cyc = 0, pops = 0, wr_cnt = 0;
  int p0, w0, t;

  fifo_arbiter #(.TAMANO_DATOS(TD), .N_FUENTES(4)) dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_alto_in(ua_in), .umbral_bajo_in(ub_in), .empty(empty),
    .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
    .dest_almost_full(af), .dest_full(full),
    .read_enable(read_enable), .write_enable(write_enable), .data_out(data_out),
    .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo), .state(state), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int src_left();
    int n = 0;
    for (int i = 0; i < 4; i++) n += srcq[i].size();
    return n;
  endfunction

  task automatic drain(input string tag);
    int n = 0;
    while ((expq.size() != 0 || src_left() != 0 || state != 2'd2) && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(n < 200), 1);
  endtask

  // Source FIFOs with registered data_out and empty flag.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset && read_enable[i] && srcq[i].size() > 0) din[i] <= srcq[i].pop_front();
    end
    for (int i = 0; i < 4; i++) empty_nx[i] = (srcq[i].size() == 0);
    empty <= empty_nx;
  end

  // Monitor: protocol rules every cycle, push-side scoreboard compare, pop-side enqueue.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      check("re_onehot", 32'($onehot0(read_enable)), 1);
      if (init || af || state < 2'd2) check("re_blocked", 32'(read_enable), 0);
      if (write_enable) begin
        wr_cnt++;
        if (expq.size() == 0) begin
          check("unexp_push", 1, 0);
        end else begin
          e = expq.pop_front();
          check("data_out", 32'(data_out), 32'(e.w));
          check("latency", cyc, e.due);
        end
      end
      if (read_enable != 4'd0) begin
        pops++;
        pcq.push_back(cyc);
        for (int i = 0; i < 4; i++) begin
          if (read_enable[i]) begin
            gq.push_back(i);
            if (srcq[i].size() == 0) check("pop_empty", 1, 0);
            else expq.push_back('{srcq[i][0], cyc + 2});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    // Reset values while reset is held, with configuration already requested.
    init = 1'b1; ua_in = 8'd6; ub_in = 8'd2;
    repeat (3) tick();
    check("rst_state", 32'(state), 0);
    check("rst_re", 32'(read_enable), 0);
    check("rst_we", 32'(write_enable), 0);
    check("rst_dout", 32'(data_out), 0);
    check("rst_ua", 32'(umbral_alto), 0);
    check("rst_ub", 32'(umbral_bajo), 0);
    check("rst_err", 32'(error), 0);

    // Release, two INIT cycles, then configuration done.
    reset = 1'b1;
    tick();
    check("init_state1", 32'(state), 1);
    tick();
    check("init_state2", 32'(state), 1);
    init = 1'b0;
    tick();
    check("idle_state", 32'(state), 2);
    check("thr_alto", 32'(umbral_alto), 6);
    check("thr_bajo", 32'(umbral_bajo), 2);
    check("idle_we", 32'(write_enable), 0);

    // All four sources loaded: grants 0,1,2,3,0 from the reset pointer.
    gq.delete(); pcq.delete();
    for (int i = 0; i < 4; i++) srcq[i].push_back(TD'(12'h100 + i));
    srcq[0].push_back(TD'(12'h104));
    drain("drain_rr");
    check("rr_count", 32'(gq.size()), 5);
    if (gq.size() == 5) begin
      check("rr_g0", gq[0], 0);
      check("rr_g1", gq[1], 1);
      check("rr_g2", gq[2], 2);
      check("rr_g3", gq[3], 3);
      check("rr_g4", gq[4], 0);
      check("rr_back2back", pcq[4] - pcq[0], 4);
    end

    // Single source, three words popped on consecutive cycles, then IDLE.
    gq.delete(); pcq.delete(); p0 = pops;
    for (int i = 1; i <= 3; i++) srcq[0].push_back(TD'(i));
    drain("drain_src0");
    check("src0_pops", pops - p0, 3);
    if (pcq.size() == 3) check("src0_consec", pcq[2] - pcq[0], 2);
    check("src0_idle", 32'(state), 2);

    // Backpressure mid-stream: no pop while high, in-flight words still pushed.
    p0 = pops; t = 0;
    for (int i = 0; i < 6; i++) srcq[1].push_back(TD'(12'h200 + i));
    while (pops - p0 < 2 && t < 50) begin tick(); t++; end
    af = 1'b1;
    repeat (3) tick();
    check("af_inflight_done", 32'(expq.size()), 0);
    check("af_no_pop", pops - p0, 2);
    af = 1'b0;
    drain("drain_af");
    check("af_all_pops", pops - p0, 6);
    check("err_clear", 32'(error), 0);

    // Push into a full destination raises the sticky error.
    full = 1'b1;
    srcq[2].push_back(TD'(12'h2AA));
    drain("drain_full");
    repeat (2) tick();
    full = 1'b0;
    repeat (3) tick();
    check("err_sticky", 32'(error), 1);

    // Reset with two words in flight: both discarded, nothing pushed afterwards.
    p0 = pops; t = 0;
    for (int i = 0; i < 4; i++) srcq[3].push_back(TD'(12'h300 + i));
    while (pops - p0 < 2 && t < 50) begin tick(); t++; end
    check("inflight_we", 32'(write_enable), 1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) srcq[i].delete();
    expq.delete();
    #1;
    check("mid_rst_we", 32'(write_enable), 0);
    check("mid_rst_re", 32'(read_enable), 0);
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_dout", 32'(data_out), 0);
    check("mid_rst_err", 32'(error), 0);
    check("mid_rst_ua", 32'(umbral_alto), 0);

    // A word waiting across reset must not be popped before INIT->IDLE.
    srcq[0].push_back(TD'(12'h3C3));
    init = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    w0 = wr_cnt;
    repeat (4) tick();
    check("no_stale_push", wr_cnt - w0, 0);
    check("init_hold", 32'(state), 1);
    init = 1'b0;
    drain("drain_post_rst");
    check("post_rst_push", wr_cnt - w0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
